ui_press_decoder: RTL and testbench

- Consumes the debounced, active-low trigger level from the UI trigger smoother.
- Decodes that level into discrete user events: a short press, a long press, and auto-repeat while the button stays held.
- Sits between the smoother and the music-box mode/menu logic, which acts only on single-cycle event pulses.
- Expects a 50 MHz clock.

---
 rtl/ui_pkg.sv | 15 +
 rtl/ui_hold_timer.sv | 34 +++
 rtl/ui_press_decoder.sv | 126 ++++++++++++
 tb/tb_ui_press_decoder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/ui_pkg.sv
// Shared types and 50 MHz default timing constants for the UI press decoder.
package ui_pkg;

    localparam int unsigned LONG_PRESS_CYCLES_DEFAULT = 50_000_000;
    localparam int unsigned REPEAT_CYCLES_DEFAULT     = 12_500_000;
    localparam int unsigned CNT_W_DEFAULT             = 26;

    typedef enum logic [1:0] {
        WAIT_RELEASE,
        IDLE,
        PRESSED,
        LONG_HELD
    } press_state_t;

endpackage

// File: rtl/ui_hold_timer.sv
// Hold-duration counter: synchronous clear has priority over increment.
module ui_hold_timer #(
    parameter int unsigned CNT_W = 26
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ui_press_decoder.sv
// Decodes the debounced active-low trigger level into short, long and
// auto-repeat single-cycle event pulses plus a registered held level.
module ui_press_decoder
    import ui_pkg::*;
#(
    parameter int unsigned LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEFAULT,
    parameter int unsigned REPEAT_CYCLES     = REPEAT_CYCLES_DEFAULT,
    parameter int unsigned CNT_W             = CNT_W_DEFAULT
) (
    input  logic clock_50Mhz,
    input  logic reset_n,
    input  logic triggerIn_n,
    input  logic repeatEn,
    output logic shortPress,
    output logic longPress,
    output logic repeatPulse,
    output logic held
);

    if ((LONG_PRESS_CYCLES < 2) || (REPEAT_CYCLES < 1) ||
        ((64'(1) << CNT_W) <= 64'(LONG_PRESS_CYCLES)) ||
        ((64'(1) << CNT_W) <= 64'(REPEAT_CYCLES))) begin : g_bad_params
        $error("ui_press_decoder: illegal LONG_PRESS_CYCLES/REPEAT_CYCLES/CNT_W");
    end

    localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_PRESS_CYCLES - 2);
    localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CYCLES - 1);

    press_state_t     state_q, state_d;
    logic             in_q;
    logic             armed_q;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             rep_q, rep_d;
    logic             held_q, held_d;
    logic             tmr_clr, tmr_en;
    logic [CNT_W-1:0] tmr_count;

    ui_hold_timer #(
        .CNT_W (CNT_W)
    ) u_hold_timer (
        .clk_i   (clock_50Mhz),
        .rst_ni  (reset_n),
        .clr_i   (tmr_clr),
        .en_i    (tmr_en),
        .count_o (tmr_count)
    );

    // armed_q keeps WAIT_RELEASE from trusting the reset value of in_q, so a
    // button held through reset must be seen released before any press counts.
    always_comb begin
        state_d = state_q;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        short_d = 1'b0;
        long_d  = 1'b0;
        rep_d   = 1'b0;
        unique case (state_q)
            WAIT_RELEASE: begin
                if (in_q && armed_q) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (!in_q) begin
                    state_d = PRESSED;
                    tmr_clr = 1'b1;
                end
            end
            PRESSED: begin
                if (in_q) begin
                    short_d = 1'b1;
                    state_d = IDLE;
                end else if (tmr_count == LONG_TERM) begin
                    long_d  = 1'b1;
                    tmr_clr = 1'b1;
                    state_d = LONG_HELD;
                end else begin
                    tmr_en  = 1'b1;
                end
            end
            LONG_HELD: begin
                if (in_q) begin
                    state_d = IDLE;
                end else if (!repeatEn) begin
                    tmr_clr = 1'b1;
                end else if (tmr_count == REPEAT_TERM) begin
                    rep_d   = 1'b1;
                    tmr_clr = 1'b1;
                end else begin
                    tmr_en  = 1'b1;
                end
            end
            default: begin
                state_d = WAIT_RELEASE;
            end
        endcase
        held_d = (state_d == PRESSED) || (state_d == LONG_HELD);
    end

    always_ff @(posedge clock_50Mhz) begin
        if (!reset_n) begin
            state_q <= WAIT_RELEASE;
            in_q    <= 1'b1;
            armed_q <= 1'b0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            in_q    <= triggerIn_n;
            armed_q <= 1'b1;
            short_q <= short_d;
            long_q  <= long_d;
            rep_q   <= rep_d;
            held_q  <= held_d;
        end
    end

    assign shortPress  = short_q;
    assign longPress   = long_q;
    assign repeatPulse = rep_q;
    assign held        = held_q;

endmodule

// File: tb/tb_ui_press_decoder.sv
// Directed bench for ui_press_decoder (LONG_PRESS_CYCLES=10, REPEAT_CYCLES=4)
// with a cycle-stamped scoreboard of expected event pulses and held windows.
module tb_ui_press_decoder;

    localparam int unsigned LONG_N = 10;
    localparam int unsigned REP_N  = 4;

    localparam logic [2:0] EV_SHORT = 3'b100;
    localparam logic [2:0] EV_LONG  = 3'b010;
    localparam logic [2:0] EV_REP   = 3'b001;

    logic clk = 1'b0;
    logic reset_n;
    logic triggerIn_n;
    logic repeatEn;
    logic shortPress;
    logic longPress;
    logic repeatPulse;
    logic held;

    always #5 clk = ~clk;

    ui_press_decoder #(
        .LONG_PRESS_CYCLES (LONG_N),
        .REPEAT_CYCLES     (REP_N),
        .CNT_W             (8)
    ) dut (
        .clock_50Mhz (clk),
        .reset_n     (reset_n),
        .triggerIn_n (triggerIn_n),
        .repeatEn    (repeatEn),
        .shortPress  (shortPress),
        .longPress   (longPress),
        .repeatPulse (repeatPulse),
        .held        (held)
    );

    typedef struct {
        int unsigned at;
        logic [2:0]  ev;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc     = 0;
    int unsigned n_vec   = 0;
    int unsigned n_err   = 0;
    bit          mon_en  = 1'b0;
    int unsigned hold_lo = 1;
    int unsigned hold_hi = 0;
    int unsigned c0;

    always @(posedge clk) cyc <= cyc + 1;

    // Every cycle: outputs must equal the scheduled event (or none) and held window.
    always @(negedge clk) begin : monitor
        logic [2:0] ev;
        logic [3:0] exp_v;
        logic [3:0] got_v;
        if (mon_en) begin
            ev = 3'b000;
            if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
                ev = exp_q[0].ev;
                void'(exp_q.pop_front());
            end
            exp_v = {(cyc >= hold_lo && cyc <= hold_hi), ev};
            got_v = {held, shortPress, longPress, repeatPulse};
            n_vec++;
            assert (got_v === exp_v) else begin
                n_err++;
                $error("FAIL outputs cyc=%0d {held,short,long,rep} got=%b exp=%b", cyc, got_v, exp_v);
            end
        end
    end

    task automatic wait_cyc(input int unsigned n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input int unsigned at, input logic [2:0] ev);
        exp_t e;
        e.at = at;
        e.ev = ev;
        exp_q.push_back(e);
    endtask

    task automatic press(input int unsigned low_cycles);
        triggerIn_n = 1'b0;
        wait_cyc(low_cycles);
        triggerIn_n = 1'b1;
    endtask

    initial begin
        reset_n     = 1'b0;
        triggerIn_n = 1'b1;
        repeatEn    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mon_en = 1'b1;
        wait_cyc(2);
        reset_n = 1'b1;
        wait_cyc(4);

        // Short press: 5 low cycles.
        c0 = cyc; hold_lo = c0 + 2; hold_hi = c0 + 6;
        push(c0 + 7, EV_SHORT);
        press(5);
        wait_cyc(6);

        // Long press with auto-repeat; release lands on the 4th repeat compare.
        c0 = cyc; hold_lo = c0 + 2; hold_hi = c0 + 26;
        push(c0 + 11, EV_LONG);
        push(c0 + 15, EV_REP);
        push(c0 + 19, EV_REP);
        push(c0 + 23, EV_REP);
        press(25);
        wait_cyc(6);

        // Long press with repeat disabled.
        repeatEn = 1'b0;
        c0 = cyc; hold_lo = c0 + 2; hold_hi = c0 + 26;
        push(c0 + 11, EV_LONG);
        press(25);
        wait_cyc(6);
        repeatEn = 1'b1;

        // Release on the long-compare cycle: short wins.
        c0 = cyc; hold_lo = c0 + 2; hold_hi = c0 + 10;
        push(c0 + 11, EV_SHORT);
        press(LONG_N - 1);
        wait_cyc(6);

        // One cycle longer: long press only, silent release.
        c0 = cyc; hold_lo = c0 + 2; hold_hi = c0 + 11;
        push(c0 + 11, EV_LONG);
        press(LONG_N);
        wait_cyc(6);

        // Reset in LONG_HELD, button kept down through reset release.
        repeatEn = 1'b0;
        c0 = cyc; hold_lo = c0 + 2; hold_hi = c0 + 13;
        push(c0 + 11, EV_LONG);
        triggerIn_n = 1'b0;
        wait_cyc(13);
        reset_n = 1'b0;
        wait_cyc(3);
        reset_n = 1'b1;
        wait_cyc(15);
        triggerIn_n = 1'b1;
        repeatEn = 1'b1;
        wait_cyc(4);

        // Normal short press after the held-through-reset release.
        c0 = cyc; hold_lo = c0 + 2; hold_hi = c0 + 6;
        push(c0 + 7, EV_SHORT);
        press(5);
        wait_cyc(6);

        mon_en = 1'b0;
        n_vec++;
        assert (exp_q.size() == 0) else begin
            n_err++;
            $error("FAIL pending_events got=%0d exp=0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
